// File: rtl/crc_frm_pkg.sv
// Shared constants and state encoding for the CRC framer and its byte selector.
package crc_frm_pkg;

  localparam int CFRM_DATA_WD     = 8;
  localparam int CFRM_CRC_WD      = 32;
  localparam int CFRM_MAX_CRC_BYT = 4;

  typedef enum logic [1:0] {
    ST_PAY  = 2'd0,
    ST_WAIT = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

endpackage

// File: rtl/crc_frm_byt_sel.sv
// Picks the CRC byte to emit for position cnt of num, in MSB-first or LSB-first order.
module crc_frm_byt_sel
  import crc_frm_pkg::*;
#(
  parameter int DATA_WD = CFRM_DATA_WD,
  parameter int CRC_WD  = CFRM_CRC_WD
) (
  input  logic [CRC_WD-1:0]  crc,
  input  logic [2:0]         cnt,
  input  logic [2:0]         num,
  input  logic               lsb_fst,
  output logic [DATA_WD-1:0] byt
);

  logic [2:0] msb_idx;
  logic [2:0] idx;

  // MSB-first walks down from the top byte of the N-byte CRC window.
  always_comb begin
    msb_idx = num - cnt - 3'd1;
    idx     = lsb_fst ? cnt : msb_idx;
    byt     = crc[int'(idx)*DATA_WD +: DATA_WD];
  end

endmodule

// File: rtl/crc_frm.sv
// Payload-to-link framer: forwards payload bytes, feeds the CRC engine, then appends 1..4 CRC bytes.
//
// state | meaning
// PAY   | forwarding payload bytes to output and CRC engine
// WAIT  | last payload byte taken, waiting for crc_val_i
// CRC   | emitting latched CRC bytes, final one carries flg_lst_o
module crc_frm
  import crc_frm_pkg::*;
#(
  parameter int DATA_WD    = CFRM_DATA_WD,
  parameter int CRC_WD     = CFRM_CRC_WD,
  parameter int NUM_BYT_WD = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_BYT_WD-1:0] cfg_num_crc_byt_i,
  input  logic                  cfg_flg_lsb_fst_i,
  input  logic                  val_i,
  output logic                  rdy_o,
  input  logic                  flg_fst_i,
  input  logic                  flg_lst_i,
  input  logic [DATA_WD-1:0]    dat_i,
  output logic                  crc_val_o,
  output logic                  crc_flg_fst_o,
  output logic                  crc_flg_lst_o,
  output logic [DATA_WD-1:0]    crc_dat_o,
  input  logic                  crc_val_i,
  input  logic [CRC_WD-1:0]     crc_dat_i,
  output logic                  val_o,
  input  logic                  rdy_i,
  output logic                  flg_fst_o,
  output logic                  flg_lst_o,
  output logic [DATA_WD-1:0]    dat_o,
  output logic                  err_o
);

  state_t             state, state_nxt;
  logic               free;
  logic               acc;
  logic               ld_crc;
  logic               crc_lst;
  logic               in_frm;
  logic               lsb_r;
  logic [2:0]         cnt;
  logic [2:0]         num_r;
  logic [2:0]         num_cfg;
  logic [CRC_WD-1:0]  crc_r;
  logic [DATA_WD-1:0] crc_byt;

  assign free = !val_o || rdy_i;

  // Out-of-range byte counts fall back to the full 4-byte CRC.
  assign num_cfg = (cfg_num_crc_byt_i == '0 ||
                    cfg_num_crc_byt_i > NUM_BYT_WD'(CFRM_MAX_CRC_BYT))
                   ? 3'(CFRM_MAX_CRC_BYT) : 3'(cfg_num_crc_byt_i);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_PAY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_PAY:  if (acc && flg_lst_i)     state_nxt = ST_WAIT;
      ST_WAIT: if (crc_val_i)            state_nxt = ST_CRC;
      ST_CRC:  if (ld_crc && crc_lst)    state_nxt = ST_PAY;
      default:                           state_nxt = ST_PAY;
    endcase
  end

  always_comb begin
    rdy_o         = (state == ST_PAY) && free;
    acc           = val_i && rdy_o;
    ld_crc        = (state == ST_CRC) && free;
    crc_lst       = (cnt == num_r - 3'd1);
    crc_val_o     = acc;
    crc_dat_o     = dat_i;
    crc_flg_fst_o = (state == ST_PAY) && !in_frm;
    crc_flg_lst_o = (state == ST_PAY) && flg_lst_i;
  end

  crc_frm_byt_sel #(
    .DATA_WD (DATA_WD),
    .CRC_WD  (CRC_WD)
  ) u_byt_sel (
    .crc     (crc_r),
    .cnt     (cnt),
    .num     (num_r),
    .lsb_fst (lsb_r),
    .byt     (crc_byt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val_o     <= 1'b0;
      flg_fst_o <= 1'b0;
      flg_lst_o <= 1'b0;
      dat_o     <= '0;
    end else if (acc) begin
      val_o     <= 1'b1;
      flg_fst_o <= !in_frm;
      flg_lst_o <= 1'b0;
      dat_o     <= dat_i;
    end else if (ld_crc) begin
      val_o     <= 1'b1;
      flg_fst_o <= 1'b0;
      flg_lst_o <= crc_lst;
      dat_o     <= crc_byt;
    end else if (free) begin
      val_o     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_frm <= 1'b0;
    end else if (acc) begin
      in_frm <= !flg_lst_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_r <= '0;
      num_r <= 3'(CFRM_MAX_CRC_BYT);
      lsb_r <= 1'b0;
      cnt   <= '0;
    end else if ((state == ST_WAIT) && crc_val_i) begin
      crc_r <= crc_dat_i;
      num_r <= num_cfg;
      lsb_r <= cfg_flg_lsb_fst_i;
      cnt   <= '0;
    end else if (ld_crc) begin
      cnt   <= cnt + 3'd1;
    end
  end

  // Framing errors are flagged but never stall or drop data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_o <= 1'b0;
    end else begin
      err_o <= (acc && (flg_fst_i == in_frm)) ||
               (crc_val_i && (state != ST_WAIT));
    end
  end

endmodule

// File: tb/tb_crc_frm.sv
// Self-checking bench for crc_frm: behavioural CRC engine, frame-level reference model, random ready/valid.
module tb_crc_frm;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [2:0]  cfg_num_crc_byt_i = 3'd4;
  logic        cfg_flg_lsb_fst_i = 1'b0;
  logic        val_i = 1'b0;
  logic        rdy_o;
  logic        flg_fst_i = 1'b0;
  logic        flg_lst_i = 1'b0;
  logic [7:0]  dat_i = 8'h00;
  logic        crc_val_o, crc_flg_fst_o, crc_flg_lst_o;
  logic [7:0]  crc_dat_o;
  logic        crc_val_i = 1'b0;
  logic [31:0] crc_dat_i = 32'h0;
  logic        val_o;
  logic        rdy_i = 1'b1;
  logic        flg_fst_o, flg_lst_o;
  logic [7:0]  dat_o;
  logic        err_o;

  always #5 clk = ~clk;

  crc_frm dut (
    .clk               (clk),
    .rstn              (rstn),
    .cfg_num_crc_byt_i (cfg_num_crc_byt_i),
    .cfg_flg_lsb_fst_i (cfg_flg_lsb_fst_i),
    .val_i             (val_i),
    .rdy_o             (rdy_o),
    .flg_fst_i         (flg_fst_i),
    .flg_lst_i         (flg_lst_i),
    .dat_i             (dat_i),
    .crc_val_o         (crc_val_o),
    .crc_flg_fst_o     (crc_flg_fst_o),
    .crc_flg_lst_o     (crc_flg_lst_o),
    .crc_dat_o         (crc_dat_o),
    .crc_val_i         (crc_val_i),
    .crc_dat_i         (crc_dat_i),
    .val_o             (val_o),
    .rdy_i             (rdy_i),
    .flg_fst_o         (flg_fst_o),
    .flg_lst_o         (flg_lst_o),
    .dat_o             (dat_o),
    .err_o             (err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // mode 0: CRC-32 (reflected, init/xorout FFFFFFFF); mode 1: CRC-16/CCITT-FALSE
  function automatic logic [31:0] crc_calc(input int md, input logic [7:0] q[$]);
    logic [31:0] c;
    logic [15:0] s;
    if (md == 0) begin
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
        c = c ^ {24'h0, q[i]};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c ^ 32'hFFFFFFFF;
    end
    s = 16'hFFFF;
    foreach (q[i]) begin
      s = s ^ {q[i], 8'h00};
      for (int b = 0; b < 8; b++) s = s[15] ? ((s << 1) ^ 16'h1021) : (s << 1);
    end
    return {16'h0, s};
  endfunction

  typedef struct packed {
    logic       fst;
    logic       lst;
    logic       crc;
    logic       c0;
    logic [7:0] dat;
  } ent_t;

  ent_t        exp_q[$];
  logic [7:0]  frm_q[$];
  logic [7:0]  eng_q[$];
  logic [7:0]  out_log[$];
  bit          in_frm_m, pend, waiting, exp_err, prev_hold;
  logic [9:0]  prev_out;
  bit          eng_fire, stray, acc_seen, single_seen, acc_c;
  logic [31:0] eng_res;
  int          mode = 0;
  int          rdy_pct = 100;
  int          cyc = 0;
  int          t_lst, t_crc0, t_crc_last, last_acc_cyc;
  int          err_cnt = 0;
  int          crc_cnt = 0;

  // Push the CRC bytes a finished frame must produce, using the configured count and order.
  task automatic push_crc(input logic [31:0] c);
    int         n;
    logic [7:0] b[4];
    n = (cfg_num_crc_byt_i == 0 || cfg_num_crc_byt_i > 4) ? 4 : int'(cfg_num_crc_byt_i);
    for (int i = 0; i < 4; i++) b[i] = 8'((c >> (8 * i)) & 32'hFF);
    for (int k = 0; k < n; k++) begin
      ent_t e;
      e.fst = 1'b0;
      e.lst = (k == n - 1);
      e.crc = 1'b1;
      e.c0  = (k == 0);
      e.dat = cfg_flg_lsb_fst_i ? b[k] : b[n - 1 - k];
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete(); frm_q.delete(); eng_q.delete();
      in_frm_m = 0; pend = 0; waiting = 0; exp_err = 0; prev_hold = 0;
      eng_fire = 0; acc_seen = 0;
    end else begin
      cyc++;
      if (prev_hold) begin
        chk("hold_val", 64'(val_o), 64'd1);
        chk("hold_dat", 64'({flg_fst_o, flg_lst_o, dat_o}), 64'(prev_out));
      end
      if (val_o && flg_lst_o) pend = 0;
      chk("err", 64'(err_o), 64'(exp_err));
      if (err_o) err_cnt++;
      if (pend) chk("rdy_busy", 64'(rdy_o), 64'd0);
      else      chk("rdy_pay", 64'(rdy_o), 64'(!val_o || rdy_i));
      if (val_o && rdy_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_byte: got %0h expected none", dat_o);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("out", 64'({flg_fst_o, flg_lst_o, dat_o}), 64'({e.fst, e.lst, e.dat}));
          out_log.push_back(dat_o);
          if (e.crc) crc_cnt++;
          if (e.c0) t_crc0 = cyc;
          if (e.lst) t_crc_last = cyc;
        end
      end
      prev_hold = val_o && !rdy_i;
      prev_out  = {flg_fst_o, flg_lst_o, dat_o};

      acc_c = val_i && rdy_o;
      chk("crc_val", 64'(crc_val_o), 64'(acc_c));
      exp_err = 0;
      acc_seen = acc_c;
      if (acc_c) begin
        chk("crc_in", 64'({crc_flg_fst_o, crc_flg_lst_o, crc_dat_o}),
            64'({!in_frm_m, flg_lst_i, dat_i}));
        if (crc_flg_fst_o && crc_flg_lst_o) single_seen = 1;
        if (flg_fst_i != !in_frm_m) exp_err = 1;
        exp_q.push_back('{fst: !in_frm_m, lst: 1'b0, crc: 1'b0, c0: 1'b0, dat: dat_i});
        if (!in_frm_m) frm_q.delete();
        frm_q.push_back(dat_i);
        in_frm_m = !flg_lst_i;
        last_acc_cyc = cyc;
        if (flg_lst_i) begin
          push_crc(crc_calc(mode, frm_q));
          pend = 1; waiting = 1; t_lst = cyc;
        end
      end
      if (crc_val_i) begin
        if (!waiting) exp_err = 1;
        waiting = 0;
      end
      if (crc_val_o) begin
        if (crc_flg_fst_o) eng_q.delete();
        eng_q.push_back(crc_dat_o);
      end
      eng_fire = crc_val_o && crc_flg_lst_o;
      if (eng_fire) eng_res = crc_calc(mode, eng_q);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    crc_val_i = eng_fire || stray;
    crc_dat_i = eng_fire ? eng_res : $urandom();
    stray     = 0;
    rdy_i     = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic f, input logic l, input int vpct);
    int g = 0;
    dat_i = d; flg_fst_i = f; flg_lst_i = l;
    forever begin
      if (!val_i) val_i = ($urandom_range(99) < vpct);
      tick();
      if (acc_seen) break;
      g++;
      if (g > 2000) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: got no acceptance expected one");
        break;
      end
    end
    val_i = 0;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input bit bad_fst, input int vpct);
    for (int i = 0; i < b.size(); i++)
      send_byte(b[i], (i == 0) && !bad_fst, i == b.size() - 1, vpct);
  endtask

  task automatic drain();
    int g = 0;
    while ((pend || exp_q.size() != 0) && g < 1000) begin
      tick();
      g++;
    end
    if (g >= 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q123[$];
    logic [7:0] q[$];
    logic [7:0] exp1[13];
    logic [7:0] exp3[5];
    int         tl;
    int         g;

    for (int i = 1; i <= 9; i++) q123.push_back(8'(8'h30 + i));
    exp1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'hCB, 8'hF4, 8'h39, 8'h26};
    exp3 = '{8'h00, 8'hD2, 8'h02, 8'hEF, 8'h8D};

    chk("model_crc32", 64'(crc_calc(0, q123)), 64'hCBF43926);
    chk("model_crc16", 64'(crc_calc(1, q123)), 64'h29B1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 64'({val_o, flg_fst_o, flg_lst_o, err_o, dat_o}), 64'd0);
    rstn = 1;
    tick();

    // CRC-32, N=4, MSB first, full throughput, then back-to-back next frame
    mode = 0; cfg_num_crc_byt_i = 3'd4; cfg_flg_lsb_fst_i = 0; rdy_pct = 100;
    out_log.delete();
    send_frame(q123, 0, 100);
    tl = t_lst;
    send_byte(8'h31, 1, 0, 100);
    chk("next_acc_lat", 64'(last_acc_cyc - tl), 64'd6);
    chk("crc0_lat", 64'(t_crc0 - tl), 64'd3);
    chk("crc_last_lat", 64'(t_crc_last - tl), 64'd6);
    send_byte(8'h32, 0, 1, 100);
    drain();
    for (int i = 0; i < 13; i++) chk("crc32_stream", 64'(out_log[i]), 64'(exp1[i]));

    // CRC-16/CCITT-FALSE, N=2, LSB first
    mode = 1; cfg_num_crc_byt_i = 3'd2; cfg_flg_lsb_fst_i = 1;
    out_log.delete();
    send_frame(q123, 0, 100);
    drain();
    chk("crc16_len", 64'(out_log.size()), 64'd11);
    chk("crc16_b0", 64'(out_log[9]), 64'hB1);
    chk("crc16_b1", 64'(out_log[10]), 64'h29);

    // single-byte frame
    mode = 0; cfg_num_crc_byt_i = 3'd4; cfg_flg_lsb_fst_i = 0;
    out_log.delete(); single_seen = 0;
    q.delete(); q.push_back(8'h00);
    send_frame(q, 0, 100);
    drain();
    chk("single_flags", 64'(single_seen), 64'd1);
    for (int i = 0; i < 5; i++) chk("single_stream", 64'(out_log[i]), 64'(exp3[i]));

    // missing first flag, then a stray engine result while idle
    err_cnt = 0;
    q.delete(); q.push_back(8'h78); q.push_back(8'h79); q.push_back(8'h7A);
    send_frame(q, 1, 100);
    drain();
    tick();
    chk("err_fst_cnt", 64'(err_cnt), 64'd1);
    stray = 1;
    tick(); tick(); tick();
    chk("err_stray_cnt", 64'(err_cnt), 64'd2);

    // reset in the middle of the CRC phase
    crc_cnt = 0;
    send_frame(q123, 0, 100);
    g = 0;
    while (crc_cnt < 2 && g < 200) begin tick(); g++; end
    chk("rst_reach", 64'(crc_cnt), 64'd2);
    rstn = 0;
    #1;
    chk("rst_mid_val", 64'(val_o), 64'd0);
    tick(); tick();
    rstn = 1;
    tick();
    out_log.delete();
    q.delete(); q.push_back(8'h41); q.push_back(8'h42);
    send_frame(q, 0, 100);
    drain();
    chk("after_rst_len", 64'(out_log.size()), 64'd6);

    // randomised frames, 50% downstream ready, random config
    rdy_pct = 50;
    for (int f = 0; f < 25; f++) begin
      int len;
      mode = int'($urandom_range(1));
      cfg_num_crc_byt_i = 3'($urandom_range(7));
      cfg_flg_lsb_fst_i = 1'($urandom_range(1));
      len = int'($urandom_range(12, 1));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom()));
      send_frame(q, 0, 70);
      drain();
    end
    tick(); tick();
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc_frm.md
Name: crc_frm

Overview:
Byte-stream framer that sits between a payload source and the link. It forwards payload bytes to the downstream consumer and in parallel drives them into the shared CRC engine. After the last payload byte it waits for the engine's result and appends 1..4 CRC bytes, so flg_lst_o marks the final CRC byte.

Parameters:
DATA_WD, 8, payload/output byte width (fixed 8; engine input width)
CRC_WD, 32, CRC result width (engine output width)
NUM_BYT_WD, 3, width of the CRC byte-count config

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
cfg_num_crc_byt_i  input  NUM_BYT_WD  CRC bytes appended, legal 1..4; 0 or >4 treated as 4
cfg_flg_lsb_fst_i  input  1  1: CRC emitted LSB byte first; 0: MSB byte first
val_i  input  1  payload byte valid
rdy_o  output  1  payload byte accepted when val_i && rdy_o
flg_fst_i  input  1  first byte of frame
flg_lst_i  input  1  last payload byte of frame
dat_i  input  DATA_WD  payload byte
crc_val_o  output  1  byte strobe to CRC engine
crc_flg_fst_o  output  1  first-byte flag to CRC engine
crc_flg_lst_o  output  1  last-byte flag to CRC engine
crc_dat_o  output  DATA_WD  byte to CRC engine
crc_val_i  input  1  CRC engine result valid, 1 cycle after the last byte
crc_dat_i  input  CRC_WD  CRC engine result, right-aligned
val_o  output  1  output byte valid
rdy_i  input  1  downstream ready
flg_fst_o  output  1  first byte of output frame
flg_lst_o  output  1  last byte of output frame (final CRC byte)
dat_o  output  DATA_WD  output byte
err_o  output  1  one-cycle framing-error pulse

Behaviour:
- One clock (clk); reset asynchronous, active-low (rstn).
- Reset values: state=PAY, in_frm=0; val_o, flg_fst_o, flg_lst_o, err_o = 0; dat_o, crc_r, cnt = 0.
- Output stage: single register (val_o/flg_*/dat_o). It is free when !val_o || rdy_i. Output holds stable while val_o && !rdy_i.
- States:
  - PAY
    - rdy_o = free.
    - Accepted byte loads the output register; latency is 1 cycle.
    - crc_val_o = val_i && rdy_o; crc_dat_o = dat_i.
    - crc_flg_fst_o = !in_frm (the internal tracker, not flg_fst_i); crc_flg_lst_o = flg_lst_i.
    - flg_fst_o = !in_frm for the accepted byte; flg_lst_o = 0 for all payload bytes.
    - in_frm sets on acceptance and clears on an accepted flg_lst_i.
    - Accepted flg_lst_i -> WAIT.
  - WAIT
    - rdy_o = 0. On crc_val_i: latch crc_r = crc_dat_i, latch byte count N (clamped) and order from cfg, set cnt = 0 -> CRC.
  - CRC
    - rdy_o = 0. Each free cycle loads byte k = cnt into the output register:
      - MSB-first: crc_r[(N-1-k)*8 +: 8]
      - LSB-first: crc_r[k*8 +: 8]
    - Loaded byte has flg_fst_o = 0 and flg_lst_o = (cnt == N-1).
    - cnt increments per load; on loading cnt == N-1 -> PAY.
- Timing with rdy_i=1: last payload byte accepted at t; out valid t+1; crc_val_i at t+1; CRC byte0 out valid t+3 (one bubble cycle at t+2); last CRC byte at t+2+N; next payload accepted from t+2+N.
- Single-byte frame (flg_fst_i && flg_lst_i): crc_flg_fst_o and crc_flg_lst_o are both 1 in the same cycle.
- err_o pulses (no state change, byte still forwarded) when:
  - an accepted byte has flg_fst_i != !in_frm
  - crc_val_i arrives while state != WAIT (value ignored)
- cfg_* must be static from the first byte of a frame until the CRC is latched. Only N and order are latched.
- Reset mid-frame: immediate return to reset state; the partial frame is dropped and no CRC is emitted. The CRC engine shares rstn.

Decomposition:
- Shared define header: state encodings (PAY/WAIT/CRC, 2 bits), DATA_WD/CRC_WD constants, and the max CRC byte count (4).
- Natural sub-module: crc_frm_byt_sel, a combinational byte selector (crc_r, cnt, N, order -> byte).
- The CRC engine is instanced beside this block by the parent, not inside it.

Test Plan:
- CRC-32 (poly 04C11DB7, init/xorout FFFFFFFF, refin/refout 1), N=4, MSB-first, payload "123456789", rdy_i=1 -> out 31..39 then CB F4 39 26; flg_lst_o only on 26; byte CB at t+3.
- CRC-16/CCITT-FALSE (1021, init FFFF, xorout 0, no reflect), N=2, LSB-first, "123456789" -> CRC bytes B1 29.
- Single byte 0x00 with fst&&lst, CRC-32 N=4 -> crc_flg_fst_o=crc_flg_lst_o=1 same cycle; out 00 D2 02 EF 8D; flg_fst_o on 00.
- rdy_i random 50% during payload and CRC phases -> no byte lost or duplicated; dat_o stable while val_o && !rdy_i; rdy_o=0 in WAIT/CRC.
- flg_fst_i=0 on first byte, then a stray crc_val_i during PAY -> err_o one-cycle pulse each; bytes still forwarded; crc_flg_fst_o=1 on first byte.
- Assert rstn during CRC phase after 2 bytes emitted -> val_o=0 immediately; next frame "AB" emits normally with correct CRC.
